// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// default frame geometry and small constant helpers.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam int         DEF_DATA_W       = 8;
  localparam int         DEF_SYNC_W       = 4;
  localparam logic [3:0] DEF_SYNC_PAT     = 4'b0110;
  localparam int         DEF_CLKS_PER_BIT = 1;
  localparam int         DEF_GAP_BITS     = 2;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-time divider: tick is high on the last clock of every bit time.
// With CLKS_PER_BIT = 1 the counter never leaves 0, so tick stays high.
module bit_tick_gen
  import seq_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int               DIV_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  // Count 0..CLKS_PER_BIT-1, wrapping on tick; held at 0 while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (clear || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter feeding the downstream "0110" sequence detector.
// Frame on y: sync pattern MSB first, data MSB first, optional even parity,
// then GAP_BITS idle-high bit times. y idles high.
// Optional build macro: SEQ_FRAME_TX_PARITY_EN adds the PARITY state.
//
// state  | meaning
// IDLE   | ready for a word, y = 1
// SYNC   | shifting out the sync pattern
// DATA   | shifting out the latched word
// PARITY | even parity bit of the latched word (macro builds only)
// GAP    | idle-high guard bits before the next frame
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT     = DEF_SYNC_PAT,
  parameter int                CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int                GAP_BITS     = DEF_GAP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              y,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = max4(SYNC_W, DATA_W, GAP_BITS, CLKS_PER_BIT);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // Unreachable when GAP_BITS = 0; clamped so the constant stays legal.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] data_sr;
  logic [SYNC_W-1:0] sync_sr;
  logic              tick;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign ready_out = (state == IDLE);
  assign busy      = (state != IDLE);

  // Divider is held cleared in IDLE so the accept edge starts a full bit time.
  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(ready_out),
    .tick (tick)
  );

  // Frame sequencer; y and frame_done are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      y          <= 1'b1;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      sync_sr    <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          y <= 1'b1;
          if (valid_in) begin
            state   <= SYNC;
            data_sr <= data_in;
            // First sync bit goes out now; the rest wait at the top of sync_sr.
            sync_sr <= SYNC_PAT << 1;
            y       <= SYNC_PAT[SYNC_W-1];
            bit_cnt <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
          end
        end

        SYNC: begin
          if (tick) begin
            if (bit_cnt == SYNC_LAST) begin
              state   <= DATA;
              bit_cnt <= '0;
              y       <= data_sr[DATA_W-1];
              data_sr <= data_sr << 1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              y       <= sync_sr[SYNC_W-1];
              sync_sr <= sync_sr << 1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
              state <= PARITY;
              y     <= parity_bit;
`else
              y <= 1'b1;
              if (GAP_BITS > 0) begin
                state <= GAP;
              end else begin
                state      <= IDLE;
                frame_done <= 1'b1;
              end
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              y       <= data_sr[DATA_W-1];
              data_sr <= data_sr << 1;
            end
          end
        end

`ifdef SEQ_FRAME_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            bit_cnt <= '0;
            y       <= 1'b1;
            if (GAP_BITS > 0) begin
              state <= GAP;
            end else begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
          end
        end
`endif

        GAP: begin
          y <= 1'b1;
          if (tick) begin
            if (bit_cnt == GAP_LAST) begin
              state      <= IDLE;
              bit_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state   <= IDLE;
          y       <= 1'b1;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: a fast (1 clock/bit) and a slow (3 clocks/bit)
// instance, each frame compared cycle by cycle against a bit list built from
// the frame rules, plus a behavioural "0110" detector on the fast line.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in   [2];
  logic       valid_in  [2];
  logic       ready_w   [2];
  logic       y_w       [2];
  logic       busy_w    [2];
  logic       done_w    [2];

  int n_total = 0;
  int n_bad   = 0;
  int last_acc = 0;

  localparam logic [3:0] SP = 4'b0110;
  localparam int GAP_N = 2;
`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  seq_frame_tx #(
    .DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b0110), .CLKS_PER_BIT(1), .GAP_BITS(2)
  ) u_fast (
    .clk(clk), .rst(rst), .data_in(data_in[0]), .valid_in(valid_in[0]),
    .ready_out(ready_w[0]), .y(y_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
  );

  seq_frame_tx #(
    .DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b0110), .CLKS_PER_BIT(3), .GAP_BITS(2)
  ) u_slow (
    .clk(clk), .rst(rst), .data_in(data_in[1]), .valid_in(valid_in[1]),
    .ready_out(ready_w[1]), .y(y_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream "0110" detector model on the fast line, one sample per bit.
  logic [3:0] hist = 4'hF;
  int det_fires = 0;
  int det_cyc   = 0;
  always @(negedge clk) begin
    hist <= {hist[2:0], y_w[0]};
    if ({hist[2:0], y_w[0]} == 4'b0110) begin
      det_fires <= det_fires + 1;
      det_cyc   <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Called #1 after a posedge with instance k in IDLE; returns #1 after the
  // edge that re-enters IDLE. keep_valid leaves valid high for a back-to-back word.
  task automatic send_frame(input int k, input logic [7:0] d, input bit keep_valid);
    bit         q[$];
    logic [3:0] sp;
    logic [7:0] dv;
    int         cpb;
    sp  = SP;
    dv  = d;
    cpb = cpb_of(k);
    for (int j = 3; j >= 0; j--)
      for (int c = 0; c < cpb; c++) q.push_back(sp[j]);
    for (int j = 7; j >= 0; j--)
      for (int c = 0; c < cpb; c++) q.push_back(dv[j]);
    if (PAR_EN)
      for (int c = 0; c < cpb; c++) q.push_back(^dv);
    for (int g = 0; g < GAP_N; g++)
      for (int c = 0; c < cpb; c++) q.push_back(1'b1);

    check_val("idle_ready", ready_w[k], 1);
    data_in[k]  = d;
    valid_in[k] = 1'b1;
    @(posedge clk); #1;
    last_acc = cyc;
    if (!keep_valid) valid_in[k] = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      check_val($sformatf("k%0d_d%0h_y%0d", k, d, i), y_w[k], q[i]);
      check_val("ready_low", ready_w[k], 0);
      check_val("busy_high", busy_w[k], 1);
      check_val("done_low", done_w[k], 0);
      data_in[k] = 8'($urandom);
      @(posedge clk); #1;
    end
    check_val($sformatf("k%0d_d%0h_frame_done", k, d), done_w[k], 1);
    check_val("end_y_idle", y_w[k], 1);
    check_val("end_ready", ready_w[k], 1);
    check_val("end_busy", busy_w[k], 0);
  endtask

  initial begin
    int  n0;
    int  k;
    bit  keep;
    bit  prev_keep;
    int  g;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_in[i]  = 8'h00;
      valid_in[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      check_val("rst_y", y_w[i], 1);
      check_val("rst_ready", ready_w[i], 1);
      check_val("rst_busy", busy_w[i], 0);
      check_val("rst_done", done_w[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic and parity words, slow rate, back-to-back.
    send_frame(0, 8'hA5, 1'b0);
    send_frame(0, 8'h01, 1'b0);
    send_frame(1, 8'hFF, 1'b0);
    send_frame(0, 8'h3C, 1'b1);
    send_frame(0, 8'hC3, 1'b0);

    // Loopback into the detector: one hit, on the last sync bit.
    n0 = det_fires;
    send_frame(0, 8'h00, 1'b0);
    check_val("det_fires", det_fires - n0, 1);
    check_val("det_pos", det_cyc - last_acc, 3);

    // Reset in the middle of DATA.
    data_in[0]  = 8'h5A;
    valid_in[0] = 1'b1;
    @(posedge clk); #1;
    valid_in[0] = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check_val("pre_rst_busy", busy_w[0], 1);
    rst = 1'b1;
    #1;
    check_val("arst_y", y_w[0], 1);
    check_val("arst_busy", busy_w[0], 0);
    check_val("arst_ready", ready_w[0], 1);
    @(posedge clk); #1;
    check_val("arst_no_done", done_w[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_no_done", done_w[0], 0);
    send_frame(0, 8'h96, 1'b0);

    // Randomized words, instances, back-to-back runs and idle gaps.
    k = 0;
    prev_keep = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!prev_keep) k = int'($urandom_range(0, 1));
      keep = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_frame(k, 8'($urandom), keep);
      prev_keep = keep;
      if (!keep) begin
        g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
